mem_port_arbiter: RTL and testbench

//  Shares one single-port backing memory between the core's instruction-fetch port and its data port.
//  - Buffers one pending request per port and arbitrates between them.
//  - Issues requests downstream and tracks outstanding reads in order.
//  - Routes each read response back to the port that issued it.
//  - Sits between PROCESSOR (imem_*/mem_* I/F) and the memory controller.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_resp_tag_fifo.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared types and encodings for the instruction/data memory port
//            arbiter: response tag encoding and the buffered data request.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Response routing tag stored per outstanding downstream read.
    typedef enum logic {
        TAG_I = 1'b0,
        TAG_D = 1'b1
    } tag_e;

    // One buffered data-port request.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } d_req_t;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_resp_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resp_tag_fifo
// Purpose  : Small in-order FIFO of response tags for outstanding downstream
//            reads. Full/empty come from the pointer wrap bits.
// Ports    : clk, rst (async, active-low)
//            push, push_data     - write side (ignored when full)
//            pop, pop_data       - read side, pop_data is the current head
//            full, empty         - status
// Revision : 1.0 - initial release
// ============================================================================
module resp_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between the instruction-fetch port
//            (i_*) and the data port (d_*). One request buffer per port, data
//            priority with an anti-starvation limit for fetches, in-order tag
//            tracking so read responses return to the issuing port.
// Ports    : clk, rst (async, active-low)
//            i_addr/i_oe            -> fetch request;  i_rdata/i_valid <- data
//            d_addr/d_oe/d_we/d_wdata -> data request; d_ready, d_rdata/d_valid
//            m_req/m_addr/m_we/m_wdata/m_gnt  downstream request handshake
//            m_rdata/m_rvalid                 downstream in-order responses
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int OUTST      = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_oe,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_oe,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid
);

    localparam int              c_SW         = $clog2(STARVE_LIM + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIM);

    // Request buffers
    logic        r_i_full;
    logic [31:0] r_i_addr;
    logic        r_d_full;
    d_req_t      r_d;
    logic        r_d_ready_q;

    // Arbitration
    logic [c_SW-1:0] r_starve;
    logic            r_lock_valid;
    logic            r_lock_d;
    logic            w_d_req;
    logic            w_d_accept;
    logic            w_d_is_store;
    logic            w_i_cand;
    logic            w_d_cand;
    logic            w_force_i;
    logic            w_sel_i;
    logic            w_sel_d;
    logic            w_i_hs;
    logic            w_d_hs;

    // Tag FIFO
    logic w_fifo_push;
    logic w_fifo_pop;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_push_tag;
    logic w_head_tag;

    // The low address bits never reach the memory.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = &{1'b0, r_d.addr[1:0]};

    assign w_d_req      = (|d_oe) || (|d_we);
    // The core samples d_ready one cycle ahead of presenting a request.
    assign w_d_accept   = w_d_req && r_d_ready_q;
    assign w_d_is_store = |r_d.we;

    // Reads need a free tag slot; stores produce no response so never wait.
    assign w_i_cand  = r_i_full && !w_fifo_full;
    assign w_d_cand  = r_d_full && (w_d_is_store || !w_fifo_full);
    assign w_force_i = r_i_full && (r_starve == c_STARVE_MAX);

    // A request left waiting for m_gnt keeps its port selected, so a newly
    // arriving data request cannot swap out the pending fetch mid-handshake.
    always_comb begin
        w_sel_i = 1'b0;
        w_sel_d = 1'b0;
        if (r_lock_valid) begin
            w_sel_d = r_lock_d;
            w_sel_i = !r_lock_d;
        end else if (w_i_cand && (!w_d_cand || w_force_i)) begin
            w_sel_i = 1'b1;
        end else if (w_d_cand) begin
            w_sel_d = 1'b1;
        end
    end

    assign w_i_hs  = w_sel_i && m_gnt;
    assign w_d_hs  = w_sel_d && m_gnt;
    assign d_ready = !r_d_full || w_d_hs;

    // Downstream request, driven straight from the selected buffer.
    always_comb begin
        m_req   = 1'b0;
        m_addr  = '0;
        m_we    = '0;
        m_wdata = '0;
        if (w_sel_d) begin
            m_req   = 1'b1;
            m_addr  = {r_d.addr[31:2], 2'b00};
            m_we    = r_d.we;
            m_wdata = r_d.wdata;
        end else if (w_sel_i) begin
            m_req   = 1'b1;
            m_addr  = r_i_addr;
        end
    end

    // Request capture. A capture in the same cycle as the grant refills the
    // buffer, so back-to-back requests issue without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_full    <= 1'b0;
            r_i_addr    <= '0;
            r_d_full    <= 1'b0;
            r_d         <= '0;
            r_d_ready_q <= 1'b1;
        end else begin
            r_d_ready_q <= d_ready;
            if (i_oe) begin
                r_i_full <= 1'b1;
                r_i_addr <= i_addr;
            end else if (w_i_hs) begin
                r_i_full <= 1'b0;
            end
            if (w_d_accept) begin
                r_d_full    <= 1'b1;
                r_d.addr    <= d_addr;
                r_d.we      <= d_we;
                r_d.wdata   <= d_wdata;
            end else if (w_d_hs) begin
                r_d_full <= 1'b0;
            end
        end
    end

    // Starvation counter and grant lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve     <= '0;
            r_lock_valid <= 1'b0;
            r_lock_d     <= 1'b0;
        end else begin
            r_lock_valid <= m_req && !m_gnt;
            r_lock_d     <= w_sel_d;
            if (!r_i_full || w_i_hs) begin
                r_starve <= '0;
            end else if (w_d_hs && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign w_fifo_push = w_i_hs || (w_d_hs && !w_d_is_store);
    assign w_push_tag  = w_sel_d ? TAG_D : TAG_I;
    assign w_fifo_pop  = m_rvalid && !w_fifo_empty;

    resp_tag_fifo #(
        .WIDTH (1),
        .DEPTH (OUTST)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_fifo_push),
        .push_data (w_push_tag),
        .pop       (w_fifo_pop),
        .pop_data  (w_head_tag),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Responses route in the same cycle they arrive.
    assign i_valid = w_fifo_pop && (w_head_tag == TAG_I);
    assign d_valid = w_fifo_pop && (w_head_tag == TAG_D);
    assign i_rdata = i_valid ? m_rdata : '0;
    assign d_rdata = d_valid ? m_rdata : '0;

    a_d_protocol : assert property (@(posedge clk) disable iff (!rst)
        !(w_d_req && !r_d_ready_q))
        else $error("data request presented while not ready; dropped");

    a_rvalid_empty : assert property (@(posedge clk) disable iff (!rst)
        !(m_rvalid && w_fifo_empty))
        else $error("response with no outstanding read; ignored");

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_oe = 1'b0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_oe = '0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic        m_gnt = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_rvalid = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.OUTST(4), .STARVE_LIM(3)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_oe(i_oe), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_addr(d_addr), .d_oe(d_oe), .d_we(d_we), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_valid(d_valid),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rdata(m_rdata), .m_rvalid(m_rvalid)
    );

    // Start a new cycle just after the edge with all pulse inputs idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        i_oe = 1'b0; d_oe = '0; d_we = '0; m_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL rst_m_req got %b want 0", m_req); end
        n_cmp++; if (m_we !== 4'h0) begin n_err++; $display("FAIL rst_m_we got %h want 0", m_we); end
        n_cmp++; if (i_valid !== 1'b0) begin n_err++; $display("FAIL rst_i_valid got %b want 0", i_valid); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rst_d_valid got %b want 0", d_valid); end
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL rst_d_ready got %b want 1", d_ready); end
        n_cmp++; if (m_addr !== 32'h0) begin n_err++; $display("FAIL rst_m_addr got %h want 0", m_addr); end
        n_cmp++; if (m_wdata !== 32'h0) begin n_err++; $display("FAIL rst_m_wdata got %h want 0", m_wdata); end
        n_cmp++; if (i_rdata !== 32'h0) begin n_err++; $display("FAIL rst_i_rdata got %h want 0", i_rdata); end
        n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_d_rdata got %h want 0", d_rdata); end
        next_cycle(); rst = 1'b1;
        next_cycle(); i_oe = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL rd_lat0_m_req got %b want 0", m_req); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL rd_issue_m_req got %b want 1", m_req); end
        n_cmp++; if (m_addr !== 32'h100) begin n_err++; $display("FAIL rd_issue_m_addr got %h want 100", m_addr); end
        n_cmp++; if (m_we !== 4'h0) begin n_err++; $display("FAIL rd_issue_m_we got %h want 0", m_we); end
        next_cycle(); m_gnt = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL rd_after_m_req got %b want 0", m_req); end
        next_cycle(); m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (i_valid !== 1'b1) begin n_err++; $display("FAIL rd_i_valid got %b want 1", i_valid); end
        n_cmp++; if (i_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_i_rdata got %h want deadbeef", i_rdata); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rd_d_valid got %b want 0", d_valid); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (i_valid !== 1'b0) begin n_err++; $display("FAIL rd_i_valid_pulse got %b want 0", i_valid); end
    endtask

    task automatic test_simultaneous();
        next_cycle(); i_oe = 1'b1; i_addr = 32'h200; d_oe = 4'hF; d_addr = 32'h300; m_gnt = 1'b1;
        @(negedge clk);
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL sim_d_ready got %b want 1", d_ready); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h300) begin n_err++; $display("FAIL sim_first_addr got %h want 300", m_addr); end
        n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL sim_first_req got %b want 1", m_req); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h200) begin n_err++; $display("FAIL sim_second_addr got %h want 200", m_addr); end
        next_cycle(); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000D0D0;
        @(negedge clk);
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL sim_rsp1_d_valid got %b want 1", d_valid); end
        n_cmp++; if (i_valid !== 1'b0) begin n_err++; $display("FAIL sim_rsp1_i_valid got %b want 0", i_valid); end
        n_cmp++; if (d_rdata !== 32'h0000D0D0) begin n_err++; $display("FAIL sim_rsp1_d_rdata got %h want d0d0", d_rdata); end
        next_cycle(); m_rvalid = 1'b1; m_rdata = 32'h00001111;
        @(negedge clk);
        n_cmp++; if (i_valid !== 1'b1) begin n_err++; $display("FAIL sim_rsp2_i_valid got %b want 1", i_valid); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL sim_rsp2_d_valid got %b want 0", d_valid); end
        n_cmp++; if (i_rdata !== 32'h00001111) begin n_err++; $display("FAIL sim_rsp2_i_rdata got %h want 1111", i_rdata); end
    endtask

    task automatic test_starvation();
        // Grants expected: D 1000, D 1004, D 1008, I 400, D 100C.
        next_cycle(); i_oe = 1'b1; i_addr = 32'h400; d_oe = 4'hF; d_addr = 32'h1000; m_gnt = 1'b1;
        next_cycle(); d_oe = 4'hF; d_addr = 32'h1004;
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h1000) begin n_err++; $display("FAIL stv_g1 got %h want 1000", m_addr); end
        next_cycle(); d_oe = 4'hF; d_addr = 32'h1008;
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h1004) begin n_err++; $display("FAIL stv_g2 got %h want 1004", m_addr); end
        next_cycle(); d_oe = 4'hF; d_addr = 32'h100C; m_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h1008) begin n_err++; $display("FAIL stv_g3 got %h want 1008", m_addr); end
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL stv_rsp_a got %b want 1", d_valid); end
        next_cycle(); m_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h400) begin n_err++; $display("FAIL stv_g4_forced_i got %h want 400", m_addr); end
        n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL stv_g4_d_ready got %b want 0", d_ready); end
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL stv_rsp_b got %b want 1", d_valid); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h100C) begin n_err++; $display("FAIL stv_g5 got %h want 100c", m_addr); end
        n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL stv_g5_req got %b want 1", m_req); end
        next_cycle(); m_gnt = 1'b0; m_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL stv_rsp_c got %b want 1", d_valid); end
        next_cycle(); m_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (i_valid !== 1'b1) begin n_err++; $display("FAIL stv_rsp_i got %b want 1", i_valid); end
        next_cycle(); m_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL stv_rsp_d got %b want 1", d_valid); end
    endtask

    task automatic test_fifo_full();
        next_cycle(); d_oe = 4'hF; d_addr = 32'h2000; m_gnt = 1'b1;
        next_cycle(); d_oe = 4'hF; d_addr = 32'h2004;
        next_cycle(); d_oe = 4'hF; d_addr = 32'h2008;
        next_cycle(); d_oe = 4'hF; d_addr = 32'h200C;
        next_cycle(); d_we = 4'h3; d_addr = 32'h2100; d_wdata = 32'hCAFE0003;
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h200C) begin n_err++; $display("FAIL ff_load4 got %h want 200c", m_addr); end
        next_cycle(); d_oe = 4'hF; d_addr = 32'h2010;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL ff_store_req got %b want 1", m_req); end
        n_cmp++; if (m_we !== 4'h3) begin n_err++; $display("FAIL ff_store_we got %h want 3", m_we); end
        n_cmp++; if (m_wdata !== 32'hCAFE0003) begin n_err++; $display("FAIL ff_store_wdata got %h want cafe0003", m_wdata); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL ff_load5_held got %b want 0", m_req); end
        n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL ff_d_ready got %b want 0", d_ready); end
        next_cycle(); m_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL ff_load5_held2 got %b want 0", m_req); end
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL ff_rsp got %b want 1", d_valid); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL ff_load5_issue got %b want 1", m_req); end
        n_cmp++; if (m_addr !== 32'h2010) begin n_err++; $display("FAIL ff_load5_addr got %h want 2010", m_addr); end
        for (int k = 0; k < 4; k++) begin
            next_cycle(); m_gnt = 1'b0; m_rvalid = 1'b1;
            @(negedge clk);
            n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL ff_drain%0d got %b want 1", k, d_valid); end
        end
    endtask

    task automatic test_backpressure();
        next_cycle(); m_gnt = 1'b0; d_we = 4'hF; d_addr = 32'h3000; d_wdata = 32'h12345678;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++;
            if (m_req !== 1'b1 || m_addr !== 32'h3000 || m_we !== 4'hF || m_wdata !== 32'h12345678) begin
                n_err++;
                $display("FAIL bp_hold%0d got req=%b addr=%h we=%h wdata=%h want 1/3000/f/12345678", k, m_req, m_addr, m_we, m_wdata);
            end
            n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL bp_d_ready%0d got %b want 0", k, d_ready); end
        end
        next_cycle(); m_gnt = 1'b1;
        @(negedge clk);
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_d_ready got %b want 1", d_ready); end
        next_cycle(); m_gnt = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL bp_after_m_req got %b want 0", m_req); end
    endtask

    task automatic test_reset_midflight();
        next_cycle(); d_oe = 4'hF; d_addr = 32'h4000; m_gnt = 1'b1;
        next_cycle(); d_oe = 4'hF; d_addr = 32'h4004;
        next_cycle(); m_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            next_cycle(); rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00000BAD;
            @(negedge clk);
            n_cmp++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin n_err++; $display("FAIL mf_rst_valid%0d got i=%b d=%b want 0/0", k, i_valid, d_valid); end
        end
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL mf_release_m_req got %b want 0", m_req); end
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL mf_release_d_ready got %b want 1", d_ready); end
        next_cycle(); i_oe = 1'b1; i_addr = 32'h4200; m_gnt = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'h4200) begin n_err++; $display("FAIL mf_i_issue got %h want 4200", m_addr); end
        next_cycle(); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000600D;
        @(negedge clk);
        // Stale D tags would misroute this to the data port.
        n_cmp++; if (i_valid !== 1'b1) begin n_err++; $display("FAIL mf_i_valid got %b want 1", i_valid); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL mf_d_valid got %b want 0", d_valid); end
        n_cmp++; if (i_rdata !== 32'h0000600D) begin n_err++; $display("FAIL mf_i_rdata got %h want 600d", i_rdata); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_starvation();
        test_fifo_full();
        test_backpressure();
        test_reset_midflight();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
